// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: sequences one 4-bit ripple-carry slice over the
// operands, least significant nibble first, carrying between nibbles in a register.

module rcarry_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_s,
  output logic       o_cout
);

  logic [4:0] w_carry;

  // Plain ripple chain inside the slice; this is the only combinational carry path.
  always_comb begin
    w_carry    = '0;
    o_s        = '0;
    w_carry[0] = i_cin;
    for (int i = 0; i < 4; i++) begin
      o_s[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
      w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [3:0]       w_nibA;
  logic [3:0]       w_nibB;
  logic [3:0]       w_s;
  logic             w_sliceCout;
  logic [WIDTH-1:0] w_accNext;
  logic             w_lastNib;

  assign w_nibA    = r_opA[4*r_cnt +: 4];
  assign w_nibB    = r_opB[4*r_cnt +: 4];
  assign w_lastNib = (r_cnt == CNT_W'(NIB - 1));

  rcarry_4bit u_slice (
    .i_a    (w_nibA),
    .i_b    (w_nibB),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_sliceCout)
  );

  // On the last nibble every lower nibble is already in r_acc, so this is the full sum.
  always_comb begin
    w_accNext                = r_acc;
    w_accNext[4*r_cnt +: 4]  = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_opA   <= '0;
      r_opB   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_opA   <= a;
            r_opB   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_state <= ADD;
          end else begin
            r_state <= IDLE;
          end
        end
        ADD: begin
          r_acc   <= w_accNext;
          r_carry <= w_sliceCout;
          if (w_lastNib) begin
            r_cnt   <= '0;
            r_sum   <= w_accNext;
            r_cout  <= w_sliceCout;
            r_state <= DONE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == ADD);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random operands,
// compared against plain-arithmetic expectations (a+b+cin).

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        cin16 = 1'b0;
  logic        busy16;
  logic        done16;
  logic [15:0] sum16;
  logic        cout16;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4;
  logic        done4;
  logic [3:0]  sum4;
  logic        cout4;

  int nAsserts = 0;
  int nFail    = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder #(.WIDTH(16)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start16),
    .a     (a16),
    .b     (b16),
    .cin   (cin16),
    .busy  (busy16),
    .done  (done16),
    .sum   (sum16),
    .cout  (cout16)
  );

  nibble_serial_adder #(.WIDTH(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  // Reference: the full-width arithmetic sum, carry out is bit 16.
  function automatic logic [16:0] refAdd16(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'b0, c};
  endfunction

  function automatic logic [4:0] refAdd4(input logic [3:0] x, input logic [3:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {4'b0, c};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
      else begin
        nFail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Called at a negedge; returns just after the accepting edge with operands scrambled.
  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
    start16 = 1'b1;
    a16     = x;
    b16     = y;
    cin16   = c;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16     = 16'($urandom);
    b16     = 16'($urandom);
    cin16   = 1'($urandom);
  endtask

  // Samples at negedges until done; counts busy cycles seen on the way.
  task automatic waitDone16(output int busyCycles);
    int guard;
    busyCycles = 0;
    guard      = 0;
    @(negedge clk);
    while (!done16 && guard < 40) begin
      if (busy16) busyCycles++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 40) checkOutput("done16_timeout", 32'(done16), 32'd1);
  endtask

  task automatic runOp16(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] expv;
    int          nb;
    expv = refAdd16(x, y, c);
    applyStimulus(x, y, c);
    waitDone16(nb);
    checkOutput({tag, "_busy"}, 32'(nb), 32'd4);
    checkOutput({tag, "_sum"},  32'(sum16), 32'(expv[15:0]));
    checkOutput({tag, "_cout"}, 32'(cout16), 32'(expv[16]));
    @(negedge clk);
    checkOutput({tag, "_done_pulse"}, 32'(done16), 32'd0);
    checkOutput({tag, "_sum_hold"}, 32'(sum16), 32'(expv[15:0]));
  endtask

  initial begin
    int          nb;
    int          t1;
    int          t2;
    int          doneSeen;
    logic [16:0] expv;
    logic [4:0]  exp4;
    logic [15:0] rx;
    logic [15:0] ry;
    logic        rc;

    // Reset state
    #2;
    checkOutput("reset_busy", 32'(busy16), 32'd0);
    checkOutput("reset_done", 32'(done16), 32'd0);
    checkOutput("reset_sum",  32'(sum16),  32'd0);
    checkOutput("reset_cout", 32'(cout16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy16), 32'd0);

    // Directed arithmetic cases
    runOp16("basic",   16'h1234, 16'h4321, 1'b0);
    runOp16("carry",   16'hFFFF, 16'h0001, 1'b0);
    runOp16("allones", 16'hFFFF, 16'hFFFF, 1'b1);

    // Start while busy is ignored
    expv = refAdd16(16'h00F0, 16'h0010, 1'b0);
    applyStimulus(16'h00F0, 16'h0010, 1'b0);
    @(posedge clk);
    #1;
    start16 = 1'b1;
    a16     = 16'hAAAA;
    b16     = 16'h5555;
    checkOutput("busy_sum_hidden", 32'(sum16), 32'h0000FFFF);
    @(posedge clk);
    #1;
    start16 = 1'b0;
    waitDone16(nb);
    checkOutput("ignore_busy", 32'(nb), 32'd2);
    checkOutput("ignore_sum",  32'(sum16), 32'(expv[15:0]));
    checkOutput("ignore_cout", 32'(cout16), 32'(expv[16]));
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16) doneSeen++;
    end
    checkOutput("ignore_single_done", 32'(doneSeen), 32'd0);

    // Reset during the third ADD cycle
    applyStimulus(16'h0F0F, 16'h0101, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(busy16), 32'd0);
    checkOutput("midrst_done", 32'(done16), 32'd0);
    checkOutput("midrst_sum",  32'(sum16),  32'd0);
    checkOutput("midrst_cout", 32'(cout16), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done16 || busy16) doneSeen++;
    end
    checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);
    checkOutput("midrst_sum_zero", 32'(sum16), 32'd0);
    runOp16("after_rst", 16'h7777, 16'h1111, 1'b1);

    // Start held high: back-to-back operations
    start16 = 1'b1;
    a16     = 16'h0001;
    b16     = 16'h0002;
    cin16   = 1'b0;
    @(posedge clk);
    #1;
    a16 = 16'h8000;
    b16 = 16'h8000;
    waitDone16(nb);
    t1 = cyc;
    checkOutput("b2b_sum1",  32'(sum16),  32'h3);
    checkOutput("b2b_cout1", 32'(cout16), 32'd0);
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16     = 16'h1234;
    b16     = 16'h1234;
    waitDone16(nb);
    t2 = cyc;
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'd5);
    checkOutput("b2b_sum2",  32'(sum16),  32'h0);
    checkOutput("b2b_cout2", 32'(cout16), 32'd1);
    @(negedge clk);

    // Random operands
    for (int k = 0; k < 12; k++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
      runOp16("random", rx, ry, rc);
    end

    // WIDTH=4 instance
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
      end else begin
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      end
      exp4   = refAdd4(a4, b4, cin4);
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      a4     = 4'($urandom);
      b4     = 4'($urandom);
      @(negedge clk);
      checkOutput("w4_busy", 32'(busy4), 32'd1);
      @(negedge clk);
      checkOutput("w4_done", 32'(done4), 32'd1);
      checkOutput("w4_sum",  32'(sum4),  32'(exp4[3:0]));
      checkOutput("w4_cout", 32'(cout4), 32'(exp4[4]));
      @(negedge clk);
      checkOutput("w4_done_pulse", 32'(done4), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
